// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a 2-entry skid buffer, flush/start gating
// and saturating stall/bubble counters. state_o exposes the FSM for debug.
module pipe_stage_reg #(
   parameter int unsigned CTRL_W              = 8,
   parameter int unsigned DATA_W              = 128,
   parameter int unsigned CLEAR_DATA_ON_FLUSH = 1,
   parameter int unsigned CNT_W               = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  bubble_cnt_o,
   output logic [1:0]        state_o
);

   // Handshake: a beat moves on a port exactly when valid & ready are both 1 at a
   // rising edge; valid never waits on ready, and in_ready_o never looks at out_ready_i.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b10,
      SKID  = 2'b11
   } state_t;

   state_t            state;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;
   logic              skid_valid;
   logic              in_fire, out_fire, kill;
   logic              stall_cond, bubble_cond;

   assign skid_valid  = state[0];
   assign out_valid_o = state[1];
   assign out_ctrl_o  = main_ctrl;
   assign out_data_o  = main_data;
   assign state_o     = state;

   assign in_ready_o  = start_i & ~skid_valid;
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;
   assign kill        = flush_i | ~start_i;
   assign stall_cond  = out_valid_o & ~out_ready_i;
   assign bubble_cond = start_i & ~out_valid_o;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= EMPTY;
         main_ctrl <= '0;
         skid_ctrl <= '0;
         main_data <= '0;
         skid_data <= '0;
      end else if (kill) begin
         // Kill wins over any transfer; an offered beat is dropped on the floor.
         state     <= EMPTY;
         main_ctrl <= '0;
         skid_ctrl <= '0;
         if (CLEAR_DATA_ON_FLUSH != 0) begin
            main_data <= '0;
            skid_data <= '0;
         end
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state     <= FULL;
                  main_ctrl <= in_ctrl_i;
                  main_data <= in_data_i;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_ctrl <= in_ctrl_i;
                  main_data <= in_data_i;
               end else if (in_fire) begin
                  state     <= SKID;
                  skid_ctrl <= in_ctrl_i;
                  skid_data <= in_data_i;
               end else if (out_fire) begin
                  state <= EMPTY;
               end
            end
            SKID: begin
               if (out_fire) begin
                  state     <= FULL;
                  main_ctrl <= skid_ctrl;
                  main_data <= skid_data;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o  <= '0;
         bubble_cnt_o <= '0;
      end else begin
         if (stall_cond && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         if (bubble_cond && (bubble_cnt_o != '1))
            bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      end
   end

`ifndef SYNTHESIS
   // A skid entry without a main entry would reorder beats.
   a_no_orphan_skid : assert property (@(posedge clk_i) disable iff (!rst_i) state_o != 2'b01);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (default, data-held-on-flush, 4-bit counters)
// share one stimulus and are checked every cycle against a queue model.
module tb_pipe_stage_reg;

   localparam int CW = 8;
   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          out_ready_i = 1'b0;
   logic [CW-1:0] in_ctrl_i = '0;
   logic [DW-1:0] in_data_i = '0;

   logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
   logic [CW-1:0] a_ctrl, b_ctrl, c_ctrl;
   logic [DW-1:0] a_data, b_data, c_data;
   logic [15:0]   a_stall, a_bubble, b_stall, b_bubble;
   logic [3:0]    c_stall, c_bubble;
   logic [1:0]    a_state, b_state, c_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1), .CNT_W(16)) dut_a (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(a_in_ready), .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
      .out_valid_o(a_out_valid), .out_ready_i(out_ready_i), .out_ctrl_o(a_ctrl), .out_data_o(a_data),
      .stall_cnt_o(a_stall), .bubble_cnt_o(a_bubble), .state_o(a_state));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(0), .CNT_W(16)) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(b_in_ready), .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
      .out_valid_o(b_out_valid), .out_ready_i(out_ready_i), .out_ctrl_o(b_ctrl), .out_data_o(b_data),
      .stall_cnt_o(b_stall), .bubble_cnt_o(b_bubble), .state_o(b_state));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1), .CNT_W(4)) dut_c (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(c_in_ready), .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
      .out_valid_o(c_out_valid), .out_ready_i(out_ready_i), .out_ctrl_o(c_ctrl), .out_data_o(c_data),
      .stall_cnt_o(c_stall), .bubble_cnt_o(c_bubble), .state_o(c_state));

   function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
      return {c, 8'hC3, ~c, 8'h5A};
   endfunction

   function automatic logic [63:0] sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? 64'(mx) : 64'(v);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: the stage is a FIFO of at most two beats; kill empties it.
   logic [CW+DW-1:0] exp_q[$];
   int m_stall  = 0;
   int m_bubble = 0;

   always @(posedge clk_i or negedge rst_i) begin
      bit acc, con;
      if (!rst_i) begin
         exp_q.delete();
         m_stall  = 0;
         m_bubble = 0;
      end else begin
         acc = in_valid_i && start_i && (exp_q.size() < 2);
         con = (exp_q.size() > 0) && out_ready_i;
         if ((exp_q.size() > 0) && !out_ready_i) m_stall++;
         if (start_i && (exp_q.size() == 0)) m_bubble++;
         if (flush_i || !start_i) exp_q.delete();
         else begin
            if (con) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({in_ctrl_i, in_data_i});
         end
      end
   end

   always @(negedge clk_i) begin
      logic [CW+DW-1:0] h;
      logic             ev, er;
      logic [1:0]       es;
      ev = exp_q.size() > 0;
      er = start_i && (exp_q.size() < 2);
      es = {exp_q.size() > 0, exp_q.size() == 2};
      check("a_in_ready", a_in_ready, er);
      check("b_in_ready", b_in_ready, er);
      check("c_in_ready", c_in_ready, er);
      check("a_out_valid", a_out_valid, ev);
      check("b_out_valid", b_out_valid, ev);
      check("c_out_valid", c_out_valid, ev);
      check("a_state", a_state, es);
      check("b_state", b_state, es);
      check("c_state", c_state, es);
      if (ev) begin
         h = exp_q[0];
         check("a_ctrl", a_ctrl, h[CW+DW-1:DW]);
         check("b_ctrl", b_ctrl, h[CW+DW-1:DW]);
         check("c_ctrl", c_ctrl, h[CW+DW-1:DW]);
         check("a_data", a_data, h[DW-1:0]);
         check("b_data", b_data, h[DW-1:0]);
         check("c_data", c_data, h[DW-1:0]);
      end
      check("a_stall", a_stall, sat(m_stall, 16));
      check("b_stall", b_stall, sat(m_stall, 16));
      check("c_stall", c_stall, sat(m_stall, 4));
      check("a_bubble", a_bubble, sat(m_bubble, 16));
      check("b_bubble", b_bubble, sat(m_bubble, 16));
      check("c_bubble", c_bubble, sat(m_bubble, 4));
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [CW-1:0] c);
      in_valid_i = v;
      in_ctrl_i  = c;
      in_data_i  = mk_data(c);
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      start_i = 1'b0;
      flush_i = 1'b0;
      out_ready_i = 1'b0;
      drive(1'b0, '0);
      cyc();
      cyc();
      rst_i = 1'b1;
      cyc();
   endtask

   initial begin
      logic [15:0]   rdy_pat;
      logic [CW-1:0] nxt;
      logic          take;
      #2;
      do_reset();
      check("rst_valid", a_out_valid, 1'b0);
      check("rst_ctrl", a_ctrl, 8'h00);
      check("rst_data", a_data, 32'h0);
      check("rst_stall", a_stall, 16'd0);
      check("rst_bubble", a_bubble, 16'd0);

      // Streaming at full rate.
      start_i = 1'b1;
      out_ready_i = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, CW'(k));
         cyc();
         check("t1_valid", a_out_valid, 1'b1);
         check("t1_ctrl", a_ctrl, 64'(k));
         check("t1_ready", a_in_ready, 1'b1);
      end
      check("t1_data5", a_data, 32'h05C3FA5A);
      drive(1'b0, '0);
      cyc();
      check("t1_drain", a_out_valid, 1'b0);
      check("t1_stall", a_stall, 16'd0);

      // Back-pressure into the skid entry.
      do_reset();
      start_i = 1'b1;
      out_ready_i = 1'b1;
      drive(1'b1, 8'h11);
      cyc();
      out_ready_i = 1'b0;
      drive(1'b1, 8'h22);
      cyc();
      check("t2_ready", a_in_ready, 1'b0);
      check("t2_ctrl", a_ctrl, 8'h11);
      drive(1'b0, '0);
      repeat (2) begin
         cyc();
         check("t2_hold", a_ctrl, 8'h11);
         check("t2_hold_data", a_data, 32'h11C3EE5A);
      end
      check("t2_stall", a_stall, 16'd3);
      out_ready_i = 1'b1;
      cyc();
      check("t2_second", a_ctrl, 8'h22);
      check("t2_second_data", a_data, 32'h22C3DD5A);
      cyc();
      check("t2_empty", a_out_valid, 1'b0);

      // Flush while in SKID with a beat offered.
      do_reset();
      start_i = 1'b1;
      drive(1'b1, 8'h11);
      cyc();
      drive(1'b1, 8'h22);
      cyc();
      flush_i = 1'b1;
      drive(1'b1, 8'h33);
      cyc();
      flush_i = 1'b0;
      drive(1'b0, '0);
      check("t3_valid", a_out_valid, 1'b0);
      check("t3_ctrl_a", a_ctrl, 8'h00);
      check("t3_data_a", a_data, 32'h0);
      check("t3_ctrl_b", b_ctrl, 8'h00);
      check("t3_data_b", b_data, 32'h11C3EE5A);
      out_ready_i = 1'b1;
      repeat (2) begin
         cyc();
         check("t3_no_33", a_out_valid, 1'b0);
      end

      // Stopped stage: nothing accepted, no bubbles counted.
      do_reset();
      out_ready_i = 1'b1;
      drive(1'b1, 8'h44);
      repeat (4) begin
         cyc();
         check("t4_ready", a_in_ready, 1'b0);
         check("t4_valid", a_out_valid, 1'b0);
      end
      check("t4_bubble0", a_bubble, 16'd0);
      start_i = 1'b1;
      drive(1'b0, '0);
      cyc();
      cyc();
      check("t4_bubble2", a_bubble, 16'd2);

      // Asynchronous reset in the middle of a cycle while in SKID.
      do_reset();
      start_i = 1'b1;
      drive(1'b1, 8'h11);
      cyc();
      drive(1'b1, 8'h22);
      cyc();
      check("t5_skid", a_state, 2'b11);
      #2;
      rst_i = 1'b0;
      #1;
      check("t5_valid", a_out_valid, 1'b0);
      check("t5_ctrl", a_ctrl, 8'h00);
      check("t5_data", a_data, 32'h0);
      check("t5_stall", a_stall, 16'd0);
      check("t5_bubble", a_bubble, 16'd0);
      check("t5_ready", a_in_ready, 1'b1);
      #2;
      rst_i = 1'b1;
      out_ready_i = 1'b1;
      drive(1'b1, 8'h55);
      cyc();
      check("t5_resume", a_ctrl, 8'h55);
      check("t5_resume_v", a_out_valid, 1'b1);
      drive(1'b0, '0);
      cyc();

      // Counter saturation on the 4-bit instance.
      do_reset();
      start_i = 1'b1;
      drive(1'b1, 8'h66);
      cyc();
      drive(1'b0, '0);
      repeat (20) cyc();
      check("t6_sat4", c_stall, 4'd15);
      check("t6_cnt16", a_stall, 16'd20);
      out_ready_i = 1'b1;
      cyc();

      // Mixed back-pressure pattern with a flush in the middle.
      do_reset();
      start_i = 1'b1;
      rdy_pat = 16'b1011_0010_1110_0101;
      nxt = 8'h80;
      for (int i = 0; i < 16; i++) begin
         out_ready_i = rdy_pat[i];
         flush_i = (i == 9);
         drive(1'b1, nxt);
         take = a_in_ready;
         cyc();
         if (take) nxt = nxt + 8'd1;
      end
      flush_i = 1'b0;
      drive(1'b0, '0);
      out_ready_i = 1'b1;
      repeat (3) cyc();
      check("t7_drained", a_out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, handshaked pipeline stage register that generalises our fixed-field ID/EX-style latches.
- Carries a control bundle and a data bundle of configurable width between any two pipeline stages.
- Adds valid/ready flow control with a 2-entry skid buffer, so a back-pressured stage never drops or duplicates an instruction.
- Supports synchronous flush (bubble insertion) and a global start gate.
- Provides saturating stall and bubble counters for performance debug.

Parameters:
CTRL_W, 8, width of control bundle (MemRead/RegWrite/ALUOp-style bits); zeroed on flush/stop.
DATA_W, 128, width of data bundle (pc, operands, imm, register addresses).
CLEAR_DATA_ON_FLUSH, 1, 1: data bundle zeroed on flush/stop; 0: data held, only valid/ctrl cleared.
CNT_W, 16, width of each performance counter.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  global enable; 0 = stage stopped (acts as flush and blocks input)
flush_i  input  1  synchronous flush, kills all held entries
in_valid_i  input  1  upstream beat valid
in_ready_o  output  1  stage can accept a beat this cycle
in_ctrl_i  input  CTRL_W  upstream control bundle
in_data_i  input  DATA_W  upstream data bundle
out_valid_o  output  1  downstream beat valid
out_ready_i  input  1  downstream accepts beat
out_ctrl_o  output  CTRL_W  control bundle of head entry
out_data_o  output  DATA_W  data bundle of head entry
stall_cnt_o  output  CNT_W  cycles with out_valid_o=1, out_ready_i=0
bubble_cnt_o  output  CNT_W  cycles with start_i=1, out_valid_o=0

Behaviour:
- Storage: main entry (drives the outputs) and skid entry, each holding valid, ctrl and data. All outputs are registered; no combinational path from in_* to out_*.
- Fire conditions:
  - in_fire = in_valid_i & in_ready_o
  - out_fire = out_valid_o & out_ready_i
- in_ready_o = start_i & ~skid_valid. It depends only on state and start_i, never on out_ready_i.
- States, encoded by (main_valid, skid_valid):
  - EMPTY (0,0):
    - in_fire -> FULL, main <= in.
    - otherwise stay EMPTY.
  - FULL (1,0):
    - in_fire & out_fire -> FULL, main <= in.
    - in_fire & ~out_fire -> SKID, skid <= in.
    - ~in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - SKID (1,1): in_ready_o=0.
    - out_fire -> FULL, main <= skid.
    - otherwise hold.
  - (0,1) is unreachable; a verification assertion checks it is never entered.
- Timing: latency 1 cycle from in_fire to out_valid_o; sustained throughput 1 beat/cycle; order strictly FIFO.
- Output hold: while out_valid_o=1 & out_ready_i=0, out_ctrl_o and out_data_o hold stable.
- Flush (flush_i=1 or start_i=0), highest priority:
  - Next state EMPTY; both valids 0, both ctrl 0.
  - Data 0 if CLEAR_DATA_ON_FLUSH=1, else held.
  - A beat offered in the same cycle is discarded; with flush_i=1 and start_i=1, in_ready_o may read 1 but the beat is not stored.
  - out_fire in a flush cycle still counts as consumed downstream.
- Reset (rst_i=0, any time including mid-transfer):
  - Immediately all valids 0, ctrl 0, data 0.
  - stall_cnt_o=0, bubble_cnt_o=0.
  - in_ready_o follows start_i once the skid entry is cleared.
- Counters:
  - Increment on the clock edge when their condition was true in that cycle.
  - Saturate at 2^CNT_W-1, no wrap.
  - Not cleared by flush or start_i; cleared only by reset.
  - bubble_cnt_o does not count cycles with start_i=0.
- Simultaneous flush_i and stall conditions: stall_cnt_o still counts that cycle if its condition held.

Test Plan:
1. Reset, then start_i=1, in_valid_i=1 streaming ctrl 0x01..0x05, out_ready_i=1 -> out_valid_o from cycle+1, ctrl 0x01..0x05 in order, in_ready_o constantly 1, stall_cnt_o=0.
2. FULL with ctrl 0x11, then out_ready_i=0 while offering 0x22 -> SKID, in_ready_o=0 next cycle, out_ctrl_o holds 0x11 for 3 stalled cycles, stall_cnt_o=3. Then out_ready_i=1 -> 0x11 then 0x22 delivered, nothing lost or duplicated.
3. In SKID, assert flush_i one cycle together with in_valid_i (ctrl 0x33) -> next cycle out_valid_o=0, out_ctrl_o=0, data 0 (param=1), 0x33 never appears. Repeat with CLEAR_DATA_ON_FLUSH=0 -> out_data_o holds its prior value.
4. start_i=0 for 4 cycles with in_valid_i=1 -> in_ready_o=0, out_valid_o=0, bubble_cnt_o unchanged. Then start_i=1, idle 2 cycles -> bubble_cnt_o +2.
5. Drop rst_i asynchronously mid-cycle while in SKID -> outputs, valids and counters 0 before the next clock edge. Release rst_i -> normal acceptance resumes.
6. CNT_W=4, hold out_ready_i=0 with a valid entry for 20 cycles -> stall_cnt_o saturates at 15.
